// File: rtl/lfsr_seq_ctrl_if.sv
// Command and output-stream signals of the LFSR sequencer.
// master: command source plus word consumer; slave: the sequencer itself.
interface lfsr_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_word;
    logic             busy;
    logic             done;
    logic             seed_err;

    modport master (
        output start, seed, len, abort, out_ready,
        input  out_valid, out_word, busy, done, seed_err
    );

    modport slave (
        input  start, seed, len, abort, out_ready,
        output out_valid, out_word, busy, done, seed_err
    );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Fibonacci LFSR sequencer: loads a seed, then emits one LFSR step per
// accepted word under valid/ready until the requested count is reached.
module lfsr_seq_ctrl #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'('hB8),
    parameter int               CNT_W = 16
) (
    input logic            clk,
    input logic            rst_b,
    lfsr_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    localparam logic [WIDTH-1:0] SEED_ONE = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] len_q;

    assign lfsr_step    = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
    assign bus.out_word = lfsr;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
        state_next    = state;
        bus.out_valid = 1'b0;
        bus.busy      = (state != IDLE);
        bus.done      = 1'b0;
        bus.seed_err  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = LOAD;
            end
            LOAD: begin
                bus.seed_err = (seed_q == '0);
                if (bus.abort)          state_next = IDLE;
                else if (len_q == '0)   state_next = DONE;
                else                    state_next = RUN;
            end
            RUN: begin
                bus.out_valid = 1'b1;
                // abort wins over a simultaneous handshake; the datapath still takes the word
                if (bus.abort)                                state_next = IDLE;
                else if (bus.out_ready && count == CNT_W'(1)) state_next = DONE;
            end
            DONE: begin
                bus.done   = !bus.abort;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            lfsr   <= '0;
            count  <= '0;
            seed_q <= '0;
            len_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        seed_q <= bus.seed;
                        len_q  <= bus.len;
                    end
                end
                LOAD: begin
                    // an all-zero seed would lock the register, so it is forced to 1
                    if (!bus.abort) begin
                        lfsr  <= (seed_q == '0) ? SEED_ONE : seed_q;
                        count <= len_q;
                    end
                end
                RUN: begin
                    if (bus.out_ready && count != '0) begin
                        lfsr  <= lfsr_step;
                        count <= count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a word-list reference model.
module tb_lfsr_seq_ctrl;
    localparam int         WIDTH = 8;
    localparam int         CNT_W = 16;
    localparam logic [7:0] TAPS  = 8'hB8;

    logic clk = 1'b0;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    lfsr_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    lfsr_seq_ctrl #(.WIDTH(WIDTH), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [7:0]      seed;
        logic [15:0]     len;
        int              rmode;   // 0: ready always, 1: ready toggles 0/1
        int              poke;    // cycle at which a stray start is raised, -1 none
        bit              exp_err;
        logic [4:0][7:0] words;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] obs_words[$];
    int         obs_err_cyc;
    int         obs_done_at;

    // Reference model state: a precomputed word list and a cursor into it
    bit         m_active;
    bit         m_loading;
    int         m_remaining;
    int         m_k;
    logic [7:0] m_word;
    logic [7:0] m_seed;
    logic [15:0] m_len;
    logic [7:0] m_seq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_next(input logic [7:0] x);
        int fb;
        fb = $countones(x & TAPS) % 2;
        return 8'((int'(x) * 2 + fb) % 256);
    endfunction

    function automatic logic [31:0] pack(input logic v, input logic b, input logic d,
                                         input logic e, input logic [7:0] w);
        return {20'd0, v, b, d, e, w};
    endfunction

    function automatic logic [31:0] status();
        return pack(bus.out_valid, bus.busy, bus.done, bus.seed_err, bus.out_word);
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.seed      = '0;
        bus.len       = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
    endtask

    // Issue one command and collect accepted words until done or the cycle budget runs out
    task automatic run_cmd(input logic [7:0] s, input logic [15:0] l, input int rmode,
                           input int poke, input int max_cyc);
        int         cyc;
        bit         stalled;
        logic [7:0] held;
        obs_words.delete();
        obs_err_cyc = -1;
        obs_done_at = -1;
        stalled     = 1'b0;
        held        = '0;
        bus.seed      = s;
        bus.len       = l;
        bus.start     = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 0;
        while (obs_done_at < 0 && cyc < max_cyc) begin
            cyc++;
            bus.start     = (cyc == poke);
            bus.out_ready = (rmode == 0) ? 1'b1 : 1'(cyc % 2);
            if (cyc == poke) begin
                bus.seed = 8'h80;
                bus.len  = 16'd1;
            end
            @(negedge clk);
            if (stalled) check($sformatf("stall_hold_c%0d", cyc), 32'(bus.out_word), 32'(held));
            stalled = 1'b0;
            if (bus.seed_err) obs_err_cyc = cyc;
            if (bus.out_valid) begin
                if (bus.out_ready) obs_words.push_back(bus.out_word);
                else begin
                    stalled = 1'b1;
                    held    = bus.out_word;
                end
            end
            if (bus.done) obs_done_at = cyc;
            @(posedge clk); #1;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] model_expect(input logic abort);
        if (!m_active)            return pack(1'b0, 1'b0, 1'b0, 1'b0, m_word);
        else if (m_loading)       return pack(1'b0, 1'b1, 1'b0, m_seed == 8'h00, m_word);
        else if (m_remaining > 0) return pack(1'b1, 1'b1, 1'b0, 1'b0, m_word);
        else                      return pack(1'b0, 1'b1, !abort, 1'b0, m_word);
    endfunction

    task automatic model_update();
        if (!m_active) begin
            if (bus.start) begin
                m_active  = 1'b1;
                m_loading = 1'b1;
                m_seed    = bus.seed;
                m_len     = bus.len;
            end
        end else if (m_loading) begin
            m_loading = 1'b0;
            if (bus.abort) m_active = 1'b0;
            else begin
                m_seq.delete();
                m_seq.push_back((m_seed == 8'h00) ? 8'h01 : m_seed);
                for (int i = 0; i < int'(m_len); i++) m_seq.push_back(ref_next(m_seq[i]));
                m_k         = 0;
                m_remaining = int'(m_len);
                m_word      = m_seq[0];
            end
        end else if (m_remaining > 0) begin
            if (bus.out_ready) begin
                m_k++;
                m_remaining--;
                m_word = m_seq[m_k];
            end
            if (bus.abort) m_active = 1'b0;
        end else begin
            m_active = 1'b0;
        end
    endtask

    initial begin
        int         exp_done;
        int         first_rep;
        logic [7:0] exp_w;

        vecs[0] = '{8'h01, 16'd5, 0, -1, 1'b0, {8'h11, 8'h08, 8'h04, 8'h02, 8'h01}};
        vecs[1] = '{8'h01, 16'd5, 1, -1, 1'b0, {8'h11, 8'h08, 8'h04, 8'h02, 8'h01}};
        vecs[2] = '{8'h00, 16'd2, 0, -1, 1'b1, {8'h00, 8'h00, 8'h00, 8'h02, 8'h01}};
        vecs[3] = '{8'h33, 16'd0, 0, -1, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[4] = '{8'h80, 16'd3, 1, -1, 1'b0, {8'h00, 8'h00, 8'h02, 8'h01, 8'h80}};
        vecs[5] = '{8'hFF, 16'd2, 0, -1, 1'b0, {8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF}};
        vecs[6] = '{8'h01, 16'd4, 0,  3, 1'b0, {8'h00, 8'h08, 8'h04, 8'h02, 8'h01}};
        vecs[7] = '{8'h01, 16'd2, 0,  4, 1'b0, {8'h00, 8'h00, 8'h00, 8'h02, 8'h01}};

        do_reset();
        @(negedge clk);
        check("reset_state", status(), 32'h0);
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            run_cmd(vecs[v].seed, vecs[v].len, vecs[v].rmode, vecs[v].poke,
                    2 * int'(vecs[v].len) + 12);
            check($sformatf("v%0d_nwords", v), 32'(obs_words.size()), 32'(vecs[v].len));
            for (int i = 0; i < int'(vecs[v].len) && i < obs_words.size(); i++)
                check($sformatf("v%0d_word%0d", v, i), 32'(obs_words[i]), 32'(vecs[v].words[i]));
            check($sformatf("v%0d_seed_err", v), 32'(obs_err_cyc), vecs[v].exp_err ? 32'd1 : 32'hFFFF_FFFF);
            if (vecs[v].len == 16'd0)    exp_done = 2;
            else if (vecs[v].rmode == 0) exp_done = int'(vecs[v].len) + 2;
            else                         exp_done = 2 * int'(vecs[v].len) + 2;
            check($sformatf("v%0d_done_cycle", v), 32'(obs_done_at), 32'(exp_done));
            @(negedge clk);
            check($sformatf("v%0d_idle_after", v), {29'd0, bus.out_valid, bus.busy, bus.done}, 32'd0);
            @(posedge clk); #1;
        end

        // Full period: word 255 repeats word 0
        run_cmd(8'h5A, 16'd256, 0, -1, 300);
        check("period_nwords", 32'(obs_words.size()), 32'd256);
        exp_w = 8'h5A;
        for (int i = 0; i < obs_words.size(); i++) begin
            check($sformatf("period_word%0d", i), 32'(obs_words[i]), 32'(exp_w));
            exp_w = ref_next(exp_w);
        end
        first_rep = -1;
        for (int i = obs_words.size() - 1; i > 0; i--)
            if (obs_words[i] == obs_words[0]) first_rep = i;
        check("period_first_repeat", 32'(first_rep), 32'd255);
        check("period_done_cycle", 32'(obs_done_at), 32'd258);

        // Abort after 3 words, coinciding with a 4th handshake
        idle_inputs();
        bus.seed = 8'h01; bus.len = 16'd10; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_run_cycle", status(), pack(1'b1, 1'b1, 1'b0, 1'b0, 8'h08));
        @(posedge clk); #1;
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("abort_idle%0d", i), status(), pack(1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
            @(posedge clk); #1;
        end

        // Asynchronous reset mid-RUN
        bus.seed = 8'h01; bus.len = 16'd10; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #1 rst_b = 1'b1;
        #1 check("async_reset", status(), 32'h0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset%0d", i), status(), 32'h0);
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model
        do_reset();
        m_active = 1'b0; m_loading = 1'b0; m_remaining = 0; m_k = 0;
        m_word = 8'h00; m_seed = 8'h00; m_len = 16'd0;
        for (int c = 0; c < 2000; c++) begin
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.seed      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.len       = 16'($urandom_range(0, 9));
            bus.abort     = ($urandom_range(0, 24) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check($sformatf("rand_c%0d", c), status(), model_expect(bus.abort));
            model_update();
            @(posedge clk); #1;
        end
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
